cp0_exception_unit: RTL and testbench
=====================================

Name: cp0_exception_unit

Overview:
- Coprocessor-0 exception/interrupt unit; owns the Cause (CP0 reg 13) and EPC (CP0 reg 14) registers plus the Status IE bit.
- Directly upstream of the CP0 read mux: cause_Out drives its reg-13 input, epc_Out drives its reg-14 input, and the mfc0 rd field drives its selector.
- Detects exceptions and interrupts, captures EPC/ExcCode, runs a two-state handler FSM, and issues one-cycle PC redirect pulses for exception entry and eret.

Parameters:
- HANDLER_ADDR, 32'h0000_0080, PC loaded on exception entry.
- IP_BIT, 10, Cause bit index reporting the pending external interrupt.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- int_Req  in  1  external interrupt request, level, asynchronous to the pipeline
- exc_Illegal  in  1  reserved/illegal instruction detected this cycle
- exc_Overflow  in  1  ALU signed overflow this cycle
- exc_Syscall  in  1  syscall decoded this cycle
- pc_Current  in  32  PC of the instruction raising or receiving the event
- mtc0_En  in  1  mtc0 write strobe
- mtc0_Sel  in  5  CP0 destination register number
- mtc0_Data  in  32  mtc0 write data
- eret  in  1  eret instruction executing
- cause_Out  out  32  Cause register
- epc_Out  out  32  EPC register
- int_Enable_Out  out  1  Status.IE
- take_Exception  out  1  one-cycle pulse: redirect PC to handler_Addr
- handler_Addr  out  32  constant HANDLER_ADDR
- eret_Redirect  out  1  one-cycle pulse: redirect PC to epc_Out

Behaviour:
- Reset (rst=1 at clk edge): Cause=0, EPC=0, IE=0, pending flop=0, state=NORMAL, take_Exception=0, eret_Redirect=0. Reset overrides all other inputs, including mid-handler.
- int_Req passes through one register (pend_q). Cause[IP_BIT] = pend_q in all states. No other Cause bits are set except ExcCode [6:2].
- ExcCode values: Int=0, Sys=8, RI=10, Ov=12.
- Priority, highest first: exc_Illegal > exc_Overflow > exc_Syscall > interrupt (pend_q & IE).
- State NORMAL, any event valid at edge:
  - EPC <= pc_Current; Cause[6:2] <= winning code; state <= HANDLER.
  - take_Exception = 1 for exactly the following cycle.
  - Latency: event cycle N gives pulse and updated registers in cycle N+1.
- State HANDLER:
  - exc_* inputs and interrupts are ignored; no nesting. pend_q keeps tracking int_Req.
  - eret=1: state <= NORMAL; eret_Redirect = 1 for the following cycle; EPC and Cause unchanged.
- eret in NORMAL: ignored, no pulse.
- Same-cycle exception and eret in NORMAL: exception taken, eret ignored.
- mtc0 writes (at edge when mtc0_En=1):
  - Sel 12: IE <= mtc0_Data[0].
  - Sel 14: EPC <= mtc0_Data.
  - Sel 13 and others: ignored; Cause is read-only.
- Same-edge conflict: exception capture beats an mtc0 EPC write. An mtc0 IE write is applied, but the interrupt decision that edge uses the old IE.
- Interrupt cannot re-fire until eret returns to NORMAL; if pend_q & IE still hold, it is taken again on the first NORMAL cycle after eret (back-to-back allowed).
- take_Exception and eret_Redirect are registered outputs and are never high in the same cycle.

Decomposition:
- Shared package cp0_pkg: CP0 register numbers (STATUS=12, CAUSE=13, EPC=14), ExcCode constants, 1-bit state encoding (NORMAL/HANDLER), HANDLER_ADDR default. The CP0 read mux uses the same register-number constants.
- One sub-module: cp0_exc_priority. Combinational; inputs are the three exc_* lines plus the interrupt qualifier; outputs are an any-event flag and the 5-bit ExcCode.

Test Plan:
- Reset: rst=1 for 2 cycles with int_Req=1 and exc_Syscall=1 -> all outputs 0, no pulses; in the first cycle after release, Cause[10]=1 and no exception is taken (IE=0).
- Overflow: pc_Current=32'h0000_0040, exc_Overflow=1 for one cycle -> next cycle take_Exception=1, epc_Out=32'h40, cause_Out[6:2]=12; pulse lasts exactly 1 cycle.
- Priority: exc_Illegal=exc_Overflow=exc_Syscall=1, IE=1, int_Req held -> ExcCode=10; then eret -> eret_Redirect pulse; the interrupt is taken the next cycle with ExcCode=0 and EPC = current pc_Current.
- Masking: IE=0, int_Req=1 -> no take_Exception and Cause[10]=1; mtc0 sel 12 data 1 -> exception taken one cycle after the write edge.
- Handler: in HANDLER, assert exc_Syscall and an mtc0 sel 14 data 32'h1234 -> no pulse, EPC=32'h1234; then eret -> eret_Redirect=1 for one cycle and epc_Out=32'h1234.
- Conflicts: exception plus mtc0 sel 14 on the same edge -> EPC=pc_Current. Exception plus eret in NORMAL -> only take_Exception. rst asserted in HANDLER -> state NORMAL, and a following eret gives no pulse.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, handler FSM
// state encoding and the default exception vector. The exception unit and
// the CP0 read mux both import this package, so register numbers are
// defined in one place.
package cp0_pkg;

    // CP0 register numbers, as seen by mtc0/mfc0.
    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    // Cause.ExcCode values.
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    // Default PC loaded on exception entry.
    localparam logic [31:0] CP0_HANDLER_ADDR = 32'h0000_0080;

    // Handler FSM: either running normal code or inside the handler.
    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } cp0_state_e;

endpackage

// File: rtl/cp0_exc_priority.sv
// Combinational exception priority encoder.
// Ports:
//   exc_illegal, exc_overflow, exc_syscall : synchronous exception sources
//   int_pending                            : interrupt already qualified by IE
//   event_valid                            : at least one source is active
//   exc_code                               : ExcCode of the winning source
// Priority, highest first: illegal > overflow > syscall > interrupt.
module cp0_exc_priority
    import cp0_pkg::*;
(
    input  logic       exc_illegal,
    input  logic       exc_overflow,
    input  logic       exc_syscall,
    input  logic       int_pending,
    output logic       event_valid,
    output logic [4:0] exc_code
);

    // NOTE: every output gets a default first, so no path through the
    // if-chain leaves a value unassigned and no latch is inferred.
    always_comb begin
        event_valid = 1'b1;
        exc_code    = EXC_INT;
        if (exc_illegal) begin
            exc_code = EXC_RI;
        end else if (exc_overflow) begin
            exc_code = EXC_OV;
        end else if (exc_syscall) begin
            exc_code = EXC_SYS;
        end else if (int_pending) begin
            exc_code = EXC_INT;
        end else begin
            event_valid = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 exception/interrupt unit. Owns Cause (reg 13), EPC (reg 14)
// and Status.IE, decides exception entry and issues one-cycle PC redirect
// pulses for exception entry and eret.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   int_Req           : external interrupt request (level, async)
//   exc_Illegal/Overflow/Syscall : exception sources for this cycle
//   pc_Current        : PC of the instruction raising/receiving the event
//   mtc0_En/Sel/Data  : mtc0 write port (Status.IE and EPC are writable)
//   eret              : eret instruction executing
//   cause_Out, epc_Out, int_Enable_Out : register contents for the read mux
//   take_Exception    : one-cycle pulse, redirect PC to handler_Addr
//   handler_Addr      : exception vector
//   eret_Redirect     : one-cycle pulse, redirect PC to epc_Out
module cp0_exception_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = CP0_HANDLER_ADDR,
    parameter int          IP_BIT       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_Req,
    input  logic        exc_Illegal,
    input  logic        exc_Overflow,
    input  logic        exc_Syscall,
    input  logic [31:0] pc_Current,
    input  logic        mtc0_En,
    input  logic [4:0]  mtc0_Sel,
    input  logic [31:0] mtc0_Data,
    input  logic        eret,
    output logic [31:0] cause_Out,
    output logic [31:0] epc_Out,
    output logic        int_Enable_Out,
    output logic        take_Exception,
    output logic [31:0] handler_Addr,
    output logic        eret_Redirect
);

    cp0_state_e  state_q;
    logic        pend_q;
    logic        ie_q;
    logic [4:0]  exc_code_q;
    logic [31:0] epc_q;
    logic        take_q;
    logic        eret_q;

    logic        event_valid;
    logic [4:0]  event_code;

    // The interrupt qualifier uses the registered IE, so an mtc0 IE write
    // only affects interrupt decisions from the following edge onwards.
    cp0_exc_priority u_priority (
        .exc_illegal  (exc_Illegal),
        .exc_overflow (exc_Overflow),
        .exc_syscall  (exc_Syscall),
        .int_pending  (pend_q & ie_q),
        .event_valid  (event_valid),
        .exc_code     (event_code)
    );

    // NOTE: sequential state uses non-blocking assignments only; several
    // writes to epc_q below rely on "last assignment wins" ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_NORMAL;
            pend_q     <= 1'b0;
            ie_q       <= 1'b0;
            exc_code_q <= EXC_INT;
            epc_q      <= '0;
            take_q     <= 1'b0;
            eret_q     <= 1'b0;
        end else begin
            // Synchroniser stage for the asynchronous interrupt line.
            pend_q <= int_Req;
            take_q <= 1'b0;
            eret_q <= 1'b0;

            if (mtc0_En && mtc0_Sel == CP0_REG_STATUS) begin
                ie_q <= mtc0_Data[0];
            end
            if (mtc0_En && mtc0_Sel == CP0_REG_EPC) begin
                epc_q <= mtc0_Data;
            end

            if (state_q == ST_NORMAL) begin
                // Exception capture comes after the mtc0 write so it wins
                // on a same-edge conflict; eret is ignored in this state.
                if (event_valid) begin
                    epc_q      <= pc_Current;
                    exc_code_q <= event_code;
                    state_q    <= ST_HANDLER;
                    take_q     <= 1'b1;
                end
            end else begin
                // No nesting: exceptions and interrupts are ignored here.
                if (eret) begin
                    state_q <= ST_NORMAL;
                    eret_q  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        cause_Out         = '0;
        cause_Out[6:2]    = exc_code_q;
        cause_Out[IP_BIT] = pend_q;
    end

    assign epc_Out        = epc_q;
    assign int_Enable_Out = ie_q;
    assign take_Exception = take_q;
    assign eret_Redirect  = eret_q;
    assign handler_Addr   = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Self-checking bench for cp0_exception_unit: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_cp0_exception_unit;

    logic        clk;
    logic        rst;
    logic        int_req;
    logic        exc_illegal;
    logic        exc_overflow;
    logic        exc_syscall;
    logic [31:0] pc_current;
    logic        mtc0_en;
    logic [4:0]  mtc0_sel;
    logic [31:0] mtc0_data;
    logic        eret;
    logic [31:0] cause_out;
    logic [31:0] epc_out;
    logic        int_enable_out;
    logic        take_exception;
    logic [31:0] handler_addr;
    logic        eret_redirect;

    cp0_exception_unit dut (
        .clk            (clk),
        .rst            (rst),
        .int_Req        (int_req),
        .exc_Illegal    (exc_illegal),
        .exc_Overflow   (exc_overflow),
        .exc_Syscall    (exc_syscall),
        .pc_Current     (pc_current),
        .mtc0_En        (mtc0_en),
        .mtc0_Sel       (mtc0_sel),
        .mtc0_Data      (mtc0_data),
        .eret           (eret),
        .cause_Out      (cause_out),
        .epc_Out        (epc_out),
        .int_Enable_Out (int_enable_out),
        .take_Exception (take_exception),
        .handler_Addr   (handler_addr),
        .eret_Redirect  (eret_redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model: architectural state as the specification describes it.
    bit        m_in_handler;
    bit        m_pend;
    bit        m_ie;
    int        m_code;
    bit [31:0] m_epc;
    bit        m_take;
    bit        m_eret;

    task automatic model_update();
        int  code;
        bit  taken;
        bit  irq;
        if (rst) begin
            m_in_handler = 0; m_pend = 0; m_ie = 0; m_code = 0;
            m_epc = 0; m_take = 0; m_eret = 0;
            return;
        end
        irq    = m_pend && m_ie;
        m_take = 0;
        m_eret = 0;
        if (mtc0_en && mtc0_sel == 5'd14) m_epc = mtc0_data;
        if (!m_in_handler) begin
            taken = 1;
            if (exc_illegal)       code = 10;
            else if (exc_overflow) code = 12;
            else if (exc_syscall)  code = 8;
            else if (irq)          code = 0;
            else begin taken = 0; code = m_code; end
            if (taken) begin
                m_epc        = pc_current;
                m_code       = code;
                m_in_handler = 1;
                m_take       = 1;
            end
        end else if (eret) begin
            m_in_handler = 0;
            m_eret       = 1;
        end
        if (mtc0_en && mtc0_sel == 5'd12) m_ie = mtc0_data[0];
        m_pend = int_req;
    endtask

    task automatic compare_all();
        check("cause", cause_out, (32'(m_pend) << 10) | (32'(m_code) << 2));
        check("epc", epc_out, m_epc);
        check("ie", {31'b0, int_enable_out}, {31'b0, m_ie});
        check("take", {31'b0, take_exception}, {31'b0, m_take});
        check("eret_redirect", {31'b0, eret_redirect}, {31'b0, m_eret});
        check("handler_addr", handler_addr, 32'h0000_0080);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        rst = 0; int_req = 0; exc_illegal = 0; exc_overflow = 0;
        exc_syscall = 0; pc_current = 0; mtc0_en = 0; mtc0_sel = 0;
        mtc0_data = 0; eret = 0;
    endtask

    task automatic mtc0(input logic [4:0] sel, input logic [31:0] data);
        mtc0_en = 1; mtc0_sel = sel; mtc0_data = data;
    endtask

    initial begin
        clear_inputs();

        // Reset with int_Req and exc_Syscall active.
        rst = 1; int_req = 1; exc_syscall = 1;
        step(); step();
        check("rst_cause", cause_out, 32'h0);
        check("rst_epc", epc_out, 32'h0);
        check("rst_take", {31'b0, take_exception}, 32'h0);
        rst = 0; exc_syscall = 0;
        step();
        check("rst_ip_after", {31'b0, cause_out[10]}, 32'h1);
        check("rst_no_take", {31'b0, take_exception}, 32'h0);

        // Overflow: one-cycle pulse, EPC and ExcCode captured.
        pc_current = 32'h40; exc_overflow = 1;
        step();
        exc_overflow = 0;
        check("ov_take", {31'b0, take_exception}, 32'h1);
        check("ov_epc", epc_out, 32'h40);
        check("ov_code", {27'b0, cause_out[6:2]}, 32'd12);
        step();
        check("ov_pulse_len", {31'b0, take_exception}, 32'h0);
        eret = 1; step(); eret = 0;
        check("ov_eret", {31'b0, eret_redirect}, 32'h1);

        // Masking: pending interrupt with IE=0, then enable via mtc0.
        step(); step();
        check("mask_take", {31'b0, take_exception}, 32'h0);
        check("mask_ip", {31'b0, cause_out[10]}, 32'h1);
        mtc0(5'd12, 32'h1);
        step();
        mtc0_en = 0;
        check("mask_ie_set", {31'b0, int_enable_out}, 32'h1);
        check("mask_old_ie", {31'b0, take_exception}, 32'h0);
        pc_current = 32'h100;
        step();
        check("mask_irq_take", {31'b0, take_exception}, 32'h1);
        check("mask_irq_code", {27'b0, cause_out[6:2]}, 32'd0);
        check("mask_irq_epc", epc_out, 32'h100);

        // Priority, then back-to-back interrupt after eret.
        eret = 1; step(); eret = 0;
        check("prio_ret", {31'b0, eret_redirect}, 32'h1);
        exc_illegal = 1; exc_overflow = 1; exc_syscall = 1; pc_current = 32'h200;
        step();
        exc_illegal = 0; exc_overflow = 0; exc_syscall = 0;
        check("prio_code", {27'b0, cause_out[6:2]}, 32'd10);
        check("prio_epc", epc_out, 32'h200);
        step();
        eret = 1; pc_current = 32'h300; step(); eret = 0;
        check("prio_eret_pulse", {31'b0, eret_redirect}, 32'h1);
        check("prio_eret_no_take", {31'b0, take_exception}, 32'h0);
        pc_current = 32'h304;
        step();
        check("b2b_take", {31'b0, take_exception}, 32'h1);
        check("b2b_code", {27'b0, cause_out[6:2]}, 32'd0);
        check("b2b_epc", epc_out, 32'h304);
        check("b2b_no_eret", {31'b0, eret_redirect}, 32'h0);

        // Quiesce the interrupt and leave the handler.
        int_req = 0; mtc0(5'd12, 32'h0); step(); mtc0_en = 0;
        step();
        eret = 1; step(); eret = 0;

        // Handler: exceptions ignored, mtc0 EPC honoured.
        exc_syscall = 1; pc_current = 32'h400;
        step();
        check("hdl_sys_code", {27'b0, cause_out[6:2]}, 32'd8);
        mtc0(5'd14, 32'h1234);
        step();
        mtc0_en = 0; exc_syscall = 0;
        check("hdl_no_pulse", {31'b0, take_exception}, 32'h0);
        check("hdl_epc_wr", epc_out, 32'h1234);
        eret = 1; step(); eret = 0;
        check("hdl_eret", {31'b0, eret_redirect}, 32'h1);
        check("hdl_eret_epc", epc_out, 32'h1234);
        step();
        check("hdl_eret_len", {31'b0, eret_redirect}, 32'h0);

        // Conflict: exception beats mtc0 EPC write on the same edge.
        exc_overflow = 1; pc_current = 32'h500; mtc0(5'd14, 32'hdead_0000);
        step();
        exc_overflow = 0; mtc0_en = 0;
        check("cf_epc", epc_out, 32'h500);
        eret = 1; step(); eret = 0;

        // Conflict: exception plus eret in NORMAL.
        exc_syscall = 1; eret = 1; pc_current = 32'h600;
        step();
        exc_syscall = 0; eret = 0;
        check("cf_take", {31'b0, take_exception}, 32'h1);
        check("cf_no_eret", {31'b0, eret_redirect}, 32'h0);
        step();
        check("cf_no_late_eret", {31'b0, eret_redirect}, 32'h0);

        // Reset while in the handler, then eret must be ignored.
        rst = 1; step(); rst = 0;
        check("rst_hdl_cause", cause_out, 32'h0);
        eret = 1; step(); eret = 0;
        check("rst_hdl_no_eret", {31'b0, eret_redirect}, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(63) == 0);
            int_req      = ($urandom_range(3) == 0);
            exc_illegal  = ($urandom_range(15) == 0);
            exc_overflow = ($urandom_range(15) == 0);
            exc_syscall  = ($urandom_range(15) == 0);
            eret         = ($urandom_range(2) == 0);
            pc_current   = $urandom & 32'hffff_fffc;
            mtc0_en      = ($urandom_range(3) == 0);
            case ($urandom_range(3))
                0: mtc0_sel = 5'd12;
                1: mtc0_sel = 5'd13;
                2: mtc0_sel = 5'd14;
                default: mtc0_sel = 5'($urandom);
            endcase
            mtc0_data = $urandom;
            step();
            check("rnd_pulse_excl",
                  {31'b0, take_exception & eret_redirect}, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
